// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of an async input in clk cycles,
// classifies the duty into one of two LED modes and flags a stuck input.
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 4095,
    parameter int MODE_THR = 326
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level,
    output logic             led0,
    output logic             led1
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] THR_V = CNT_W'(MODE_THR);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic sync1, pwm_s, pwm_d;
    logic rise, fall;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [CNT_W-1:0] hi_pend, hi_pend_n;
    logic [CNT_W-1:0] period_n, high_n;
    logic             valid_n, timeout_n, stuck_n, led0_n, led1_n;
    logic             at_to;

    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign at_to   = (cnt == TO_V);
    assign cnt_inc = at_to ? cnt : cnt + ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_pend     <= '0;
            period_out  <= '0;
            high_out    <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
            led0        <= 1'b0;
            led1        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            hi_pend     <= hi_pend_n;
            period_out  <= period_n;
            high_out    <= high_n;
            valid       <= valid_n;
            timeout     <= timeout_n;
            stuck_level <= stuck_n;
            led0        <= led0_n;
            led1        <= led1_n;
        end
    end

    // Edges are tested before the timeout so an edge on the limit cycle wins.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_inc;
        hi_pend_n = hi_pend;
        period_n  = period_out;
        high_n    = high_out;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        stuck_n   = stuck_level;
        led0_n    = led0;
        led1_n    = led1;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (rise) begin
                    state_n = HIGH;
                    cnt_n   = ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n   = LOW;
                    hi_pend_n = cnt;
                end else if (at_to) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                    stuck_n   = pwm_s;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n  = HIGH;
                    cnt_n    = ONE;
                    period_n = cnt;
                    high_n   = hi_pend;
                    valid_n  = 1'b1;
                    {led1_n, led0_n} = (hi_pend < THR_V) ? 2'b01 : 2'b10;
                end else if (at_to) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                    stuck_n   = pwm_s;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
